// File: rtl/wfifo_write_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port among NUM_REQ producers on wclk.
// Optional per-producer word counters and a full-stall counter when WARB_STATS_EN is defined.
module wfifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
   output logic                          busy
`ifdef WARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         stat_cnt,
   output logic [15:0]                   stall_cnt
`endif
);

   localparam int         IW = $clog2(NUM_REQ);
   localparam logic [3:0] MB = 4'(MAX_BURST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] gnt_q, gnt_nxt;
   logic [IW-1:0] last_q, last_nxt;
   logic [IW-1:0] winner, idx;
   logic [3:0]    burst_q, burst_nxt;
   logic          found;
   logic          grant_act;
   logic          xfer;

   // Scan starts one past the previous winner, so the last winner ranks lowest.
   always_comb begin
      winner = last_q;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(last_q) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Outputs are masked by wrst so nothing is written in the cycle reset is sampled.
   assign grant_act = (state == GRANT) && !wrst;
   assign xfer      = grant_act && req[gnt_q] && !wfull;
   assign winc      = xfer;
   assign busy      = grant_act;
   assign gnt_id    = wrst ? '0 : gnt_q;

   always_comb begin
      ack   = '0;
      wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q == IW'(i)) begin
            ack[i] = xfer;
            if (grant_act) wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      last_nxt  = last_q;
      burst_nxt = burst_q;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               gnt_nxt   = winner;
               last_nxt  = winner;
               burst_nxt = '0;
            end
         end
         GRANT: begin
            if (!req[gnt_q]) begin
               state_nxt = IDLE;
            end else if (!wfull) begin
               burst_nxt = burst_q + 4'd1;
               if (req_last[gnt_q] || (burst_q + 4'd1 == MB)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state   <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         burst_q <= '0;
      end else begin
         state   <= state_nxt;
         gnt_q   <= gnt_nxt;
         last_q  <= last_nxt;
         burst_q <= burst_nxt;
      end
   end

`ifdef WARB_STATS_EN
   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_stat
         always_ff @(posedge wclk) begin
            if (wrst)
               stat_cnt[g*16 +: 16] <= '0;
            else if (ack[g] && (stat_cnt[g*16 +: 16] != 16'hFFFF))
               stat_cnt[g*16 +: 16] <= stat_cnt[g*16 +: 16] + 16'd1;
         end
      end
   endgenerate

   always_ff @(posedge wclk) begin
      if (wrst)
         stall_cnt <= '0;
      else if (grant_act && req[gnt_q] && wfull && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_wfifo_write_arbiter.sv
// Table-driven bench for wfifo_write_arbiter; a scoreboard checks every FIFO write.
module tb_wfifo_write_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;

   logic          wclk = 1'b0;
   logic          wrst;
   logic [NR-1:0] req, req_last, ack;
   logic [NR*DW-1:0] req_data;
   logic          wfull, winc, busy;
   logic [DW-1:0] wdata;
   logic [1:0]    gnt_id;
`ifdef WARB_STATS_EN
   logic [NR*16-1:0] stat_cnt;
   logic [15:0]      stall_cnt;
`endif

   always #5 wclk = ~wclk;

   wfifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .wfull(wfull), .winc(winc), .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
`ifdef WARB_STATS_EN
      , .stat_cnt(stat_cnt), .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic          rst;
      logic [NR-1:0] req;
      logic [NR-1:0] last;
      logic          full;
      logic [NR*DW-1:0] data;
      logic          busy;
      logic          winc;
      logic [1:0]    gnt;
   } vec_t;

   vec_t       vecs[$];
   logic [DW-1:0] dval [NR];
   logic [9:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Producer data advances only on a planned acceptance, so held words stay stable.
   task automatic add(input logic rst, input logic [NR-1:0] rq, input logic [NR-1:0] lst,
                      input logic full, input logic b, input logic w, input logic [1:0] g);
      vec_t v;
      v.rst = rst; v.req = rq; v.last = lst; v.full = full;
      v.busy = b; v.winc = w; v.gnt = g;
      for (int i = 0; i < NR; i++) v.data[i*DW +: DW] = dval[i];
      vecs.push_back(v);
      if (w) dval[g] = dval[g] + 8'd1;
   endtask

   task automatic idle(input logic [NR-1:0] rq, input logic [NR-1:0] lst);
      add(1'b0, rq, lst, 1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic xf(input logic [NR-1:0] rq, input logic [NR-1:0] lst, input logic [1:0] g);
      add(1'b0, rq, lst, 1'b0, 1'b1, 1'b1, g);
   endtask

   task automatic stall(input logic [NR-1:0] rq, input logic [1:0] g);
      add(1'b0, rq, '0, 1'b1, 1'b1, 1'b0, g);
   endtask

   always @(negedge wclk) begin : mon
      logic [9:0] e;
      if (mon_en) begin
         chk("winc_while_full", 32'(winc & wfull), 32'd0);
         if (winc) begin
            chk("ack_onehot", 32'(ack), 32'(4'b0001 << gnt_id));
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: write of %0h by %0d, none expected", wdata, gnt_id);
            end else begin
               e = sb.pop_front();
               chk("sb_word", 32'({gnt_id, wdata}), 32'(e));
            end
         end else begin
            chk("ack_no_winc", 32'(ack), 32'd0);
         end
      end
   end

   initial begin
      logic [1:0] rr [5];
      rr[0] = 2'd0; rr[1] = 2'd1; rr[2] = 2'd2; rr[3] = 2'd3; rr[4] = 2'd0;
      for (int i = 0; i < NR; i++) dval[i] = 8'(i * 16);

      add(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 2'd0);
      // all request: bursts of 4, one bubble between grants
      for (int r = 0; r < 5; r++) begin
         idle(4'hF, 4'h0);
         for (int w = 0; w < 4; w++) xf(4'hF, 4'h0, rr[r]);
      end
      idle(4'h0, 4'h0);
      // 3-word packet from producer 2 ending on req_last
      dval[2] = 8'hA1;
      idle(4'b0100, 4'h0);
      xf(4'b0100, 4'h0, 2'd2);
      xf(4'b0100, 4'h0, 2'd2);
      xf(4'b0100, 4'b0100, 2'd2);
      idle(4'h0, 4'h0);
      // producer 1 stalled by wfull for 5 cycles mid-burst
      idle(4'b0010, 4'h0);
      xf(4'b0010, 4'h0, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      for (int s = 0; s < 5; s++) stall(4'b0010, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      idle(4'h0, 4'h0);
      // reset in the middle of producer 0's burst
      idle(4'b0001, 4'h0);
      xf(4'b0001, 4'h0, 2'd0);
      add(1'b1, 4'b0001, '0, 1'b0, 1'b0, 1'b0, 2'd0);
      idle(4'b0011, 4'h0);
      xf(4'b0011, 4'b0001, 2'd0);
      idle(4'b0010, 4'h0);
      xf(4'b0010, 4'b0010, 2'd1);
      idle(4'h0, 4'h0);
      // producer 3 drops req mid-burst; scan restarts at producer 0
      idle(4'b1000, 4'h0);
      xf(4'b1000, 4'h0, 2'd3);
      xf(4'b1000, 4'h0, 2'd3);
      add(1'b0, 4'b0001, '0, 1'b0, 1'b1, 1'b0, 2'd3);
      idle(4'b1001, 4'h0);
      xf(4'b1001, 4'b0001, 2'd0);
      idle(4'b1000, 4'h0);
      xf(4'b1000, 4'b1000, 2'd3);
      idle(4'h0, 4'h0);
`ifdef WARB_STATS_EN
      // 10 words from producer 1 with 3 stall cycles, counted from a fresh reset
      add(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 2'd0);
      idle(4'b0010, 4'h0);
      xf(4'b0010, 4'h0, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      for (int s = 0; s < 3; s++) stall(4'b0010, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      xf(4'b0010, 4'h0, 2'd1);
      idle(4'b0010, 4'h0);
      for (int w = 0; w < 4; w++) xf(4'b0010, 4'h0, 2'd1);
      idle(4'b0010, 4'h0);
      xf(4'b0010, 4'h0, 2'd1);
      xf(4'b0010, 4'b0010, 2'd1);
      idle(4'h0, 4'h0);
`endif

      mon_en = 1'b1;
      for (int n = 0; n < vecs.size(); n++) begin
         wrst     = vecs[n].rst;
         req      = vecs[n].req;
         req_last = vecs[n].last;
         wfull    = vecs[n].full;
         req_data = vecs[n].data;
         if (vecs[n].winc)
            sb.push_back({vecs[n].gnt, vecs[n].data[int'(vecs[n].gnt)*DW +: DW]});
         @(negedge wclk);
         chk($sformatf("busy[%0d]", n), 32'(busy), 32'(vecs[n].busy));
         chk($sformatf("winc[%0d]", n), 32'(winc), 32'(vecs[n].winc));
         if (vecs[n].busy) chk($sformatf("gnt_id[%0d]", n), 32'(gnt_id), 32'(vecs[n].gnt));
         if (vecs[n].rst) begin
            chk($sformatf("rst_gnt_id[%0d]", n), 32'(gnt_id), 32'd0);
            chk($sformatf("rst_wdata[%0d]", n), 32'(wdata), 32'd0);
            chk($sformatf("rst_ack[%0d]", n), 32'(ack), 32'd0);
         end
         @(posedge wclk);
         #1;
      end
      mon_en = 1'b0;

      chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef WARB_STATS_EN
      chk("stat_cnt0", 32'(stat_cnt[0*16 +: 16]), 32'd0);
      chk("stat_cnt1", 32'(stat_cnt[1*16 +: 16]), 32'd10);
      chk("stat_cnt2", 32'(stat_cnt[2*16 +: 16]), 32'd0);
      chk("stat_cnt3", 32'(stat_cnt[3*16 +: 16]), 32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
